// File: rtl/board_matrix_memory.sv
// -----------------------------------------------------------------------------
// board_matrix_memory
//
// Purpose:
//   Responder side of the matrix memory interface. This block holds the
//   settled-block occupancy of the playfield. It returns a 4x4 occupancy
//   window that the falling-tile logic uses for collision checks. It commits
//   a landed tile into the board, then runs a bottom-up scan that removes
//   full rows and counts them. It also has a combinational row read port for
//   the renderer.
//
// Ports:
//   clk_i            clock
//   reset_i          asynchronous active-high reset
//   mm_addr_i        window origin (top-left), point_t {x_m, y_m}
//   mm_data_o        window occupancy, [r][c] = cell (x_m+c, y_m+r); off-board reads 1
//   commit_v_i       write commit_shape_i at commit_pos_i (accepted in IDLE only)
//   commit_pos_i     tile origin
//   commit_shape_i   tile shape, same [r][c] mapping as mm_data_o
//   clear_i          empty the board (priority over everything but reset)
//   row_addr_i       renderer row select
//   row_data_o       occupancy of row_addr_i, bit c = column c; off-board reads all 1
//   ready_o          high only in IDLE
//   done_o           one-cycle pulse when commit processing ends
//   lines_cleared_o  rows cleared by the last commit
//   total_lines_o    saturating running total of cleared rows
//   overflow_o       sticky: a commit bit was off-board or hit an occupied cell
// -----------------------------------------------------------------------------

package board_matrix_memory_pkg;

    typedef struct packed {
        logic [3:0] x_m;
        logic [4:0] y_m;
    } point_t;

    typedef logic [3:0][3:0] shape_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_e;

endpackage

module board_matrix_memory
    import board_matrix_memory_pkg::*;
#(
    parameter int width_p  = 10,
    parameter int height_p = 20
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  point_t              mm_addr_i,
    output logic [3:0][3:0]     mm_data_o,
    input  logic                commit_v_i,
    input  point_t              commit_pos_i,
    input  shape_t              commit_shape_i,
    input  logic                clear_i,
    input  logic [4:0]          row_addr_i,
    output logic [width_p-1:0]  row_data_o,
    output logic                ready_o,
    output logic                done_o,
    output logic [2:0]          lines_cleared_o,
    output logic [15:0]         total_lines_o,
    output logic                overflow_o
);

    localparam int          xw_lp    = $clog2(width_p);
    localparam int          yw_lp    = $clog2(height_p);
    localparam logic [5:0]  width_c  = 6'(width_p);
    localparam logic [5:0]  height_c = 6'(height_p);

    // Board cell [y][x]; row y bit x = column x.
    logic [height_p-1:0][width_p-1:0] board_q;
    logic [height_p-1:0][width_p-1:0] commit_board;
    logic [height_p-1:0][width_p-1:0] shift_board;
    logic                             commit_ovf;

    state_e             state_q, state_d;
    logic [yw_lp-1:0]   row_q;
    logic               row_full;

    // -------------------------------------------------------------------------
    // Window read. Coordinates are widened to 6 bits so x_m+c past 15 (and the
    // x-1 wrap from 0 to 15) lands off-board and reads as a wall.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [5:0] win_x;
        logic [5:0] win_y;
        // NOTE: every variable gets a value before any branch, so no latch can be inferred.
        mm_data_o = '0;
        win_x     = '0;
        win_y     = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                win_x = {2'b00, mm_addr_i.x_m} + 6'(c);
                win_y = {1'b0, mm_addr_i.y_m} + 6'(r);
                if (win_x >= width_c || win_y >= height_c) begin
                    mm_data_o[r][c] = 1'b1;
                end else begin
                    mm_data_o[r][c] = board_q[win_y[yw_lp-1:0]][win_x[xw_lp-1:0]];
                end
            end
        end
    end

    // Renderer row port.
    always_comb begin
        if ({1'b0, row_addr_i} >= height_c) begin
            row_data_o = '1;
        end else begin
            row_data_o = board_q[row_addr_i[yw_lp-1:0]];
        end
    end

    // -------------------------------------------------------------------------
    // Commit merge: OR the in-bounds shape bits into the board. Off-board
    // bits are dropped. Off-board bits and bits that hit an occupied cell
    // both raise overflow.
    // -------------------------------------------------------------------------
    always_comb begin
        logic [5:0] cx;
        logic [5:0] cy;
        commit_board = board_q;
        commit_ovf   = 1'b0;
        cx           = '0;
        cy           = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (commit_shape_i[r][c]) begin
                    cx = {2'b00, commit_pos_i.x_m} + 6'(c);
                    cy = {1'b0, commit_pos_i.y_m} + 6'(r);
                    if (cx >= width_c || cy >= height_c) begin
                        commit_ovf = 1'b1;
                    end else begin
                        if (board_q[cy[yw_lp-1:0]][cx[xw_lp-1:0]]) begin
                            commit_ovf = 1'b1;
                        end
                        commit_board[cy[yw_lp-1:0]][cx[xw_lp-1:0]] = 1'b1;
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Row clear. Rows 1..row_q take the row above them, row 0 empties, and
    // rows below row_q are untouched. The scan stays on row_q so a row that
    // drops into place is checked again.
    // -------------------------------------------------------------------------
    assign row_full = &board_q[row_q];

    always_comb begin
        shift_board = board_q;
        for (int i = 1; i < height_p; i++) begin
            if (yw_lp'(i) <= row_q) begin
                shift_board[i] = board_q[i-1];
            end
        end
        shift_board[0] = '0;
    end

    // -------------------------------------------------------------------------
    // FSM: state register / next state / outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (commit_v_i) state_d = ST_SCAN;
                ST_SCAN: if (!row_full && row_q == '0) state_d = ST_DONE;
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ready_o = (state_q == ST_IDLE);
        done_o  = (state_q == ST_DONE);
    end

    // -------------------------------------------------------------------------
    // Board and counters.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            // NOTE: the board is built from reset flops, not RAM. The window, row-full and shift paths read every cell in parallel, and reset must empty the board.
            board_q         <= '0;
            row_q           <= '0;
            lines_cleared_o <= '0;
            total_lines_o   <= '0;
            overflow_o      <= 1'b0;
        end else if (clear_i) begin
            board_q         <= '0;
            row_q           <= '0;
            lines_cleared_o <= '0;
            overflow_o      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (commit_v_i) begin
                        board_q         <= commit_board;
                        overflow_o      <= overflow_o | commit_ovf;
                        lines_cleared_o <= '0;
                        row_q           <= yw_lp'(height_p - 1);
                    end
                end
                ST_SCAN: begin
                    if (row_full) begin
                        board_q         <= shift_board;
                        lines_cleared_o <= lines_cleared_o + 3'd1;
                        if (total_lines_o != 16'hFFFF) begin
                            total_lines_o <= total_lines_o + 16'd1;
                        end
                    end else if (row_q != '0) begin
                        row_q <= row_q - yw_lp'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_matrix_memory.sv
// -----------------------------------------------------------------------------
// tb_board_matrix_memory
//
// Purpose:
//   Self-checking bench for board_matrix_memory. A behavioural board model
//   applies each accepted commit in one step: merge the shape, drop every full
//   row, and compact the remaining rows downward. From that it derives the
//   IDLE/DONE timing. A negedge compare process checks the DUT against the
//   model on every cycle. Directed tests add hand-computed literal values.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------

module tb_board_matrix_memory;
    import board_matrix_memory_pkg::*;

    localparam int W = 10;
    localparam int H = 20;

    logic             clk_i = 1'b0;
    logic             reset_i;
    point_t           mm_addr_i;
    logic [3:0][3:0]  mm_data_o;
    logic             commit_v_i;
    point_t           commit_pos_i;
    shape_t           commit_shape_i;
    logic             clear_i;
    logic [4:0]       row_addr_i;
    logic [W-1:0]     row_data_o;
    logic             ready_o;
    logic             done_o;
    logic [2:0]       lines_cleared_o;
    logic [15:0]      total_lines_o;
    logic             overflow_o;

    board_matrix_memory #(.width_p(W), .height_p(H)) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .mm_addr_i       (mm_addr_i),
        .mm_data_o       (mm_data_o),
        .commit_v_i      (commit_v_i),
        .commit_pos_i    (commit_pos_i),
        .commit_shape_i  (commit_shape_i),
        .clear_i         (clear_i),
        .row_addr_i      (row_addr_i),
        .row_data_o      (row_data_o),
        .ready_o         (ready_o),
        .done_o          (done_o),
        .lines_cleared_o (lines_cleared_o),
        .total_lines_o   (total_lines_o),
        .overflow_o      (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    bit checking = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    bit [W-1:0] m_board [H];
    int         m_scan_left = 0;   // cycles of SCAN still to come
    bit         m_done      = 1'b0;
    logic [2:0] m_lines     = '0;
    int         m_total     = 0;
    bit         m_ovf       = 1'b0;

    function automatic logic [15:0] model_win(input int xm, input int ym);
        logic [15:0] w;
        w = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (xm + c >= W || ym + r >= H) w[r*4+c] = 1'b1;
                else                            w[r*4+c] = m_board[ym+r][xm+c];
            end
        end
        return w;
    endfunction

    function automatic logic [W-1:0] model_row(input int a);
        if (a >= H) return '1;
        return m_board[a];
    endfunction

    task automatic model_reset_board();
        for (int y = 0; y < H; y++) m_board[y] = '0;
    endtask

    task automatic model_commit(input int xm, input int ym, input logic [15:0] sh);
        bit [W-1:0] kept[$];
        int         n;
        n = 0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (sh[r*4+c]) begin
                    if (xm + c >= W || ym + r >= H) begin
                        m_ovf = 1'b1;
                    end else begin
                        if (m_board[ym+r][xm+c]) m_ovf = 1'b1;
                        m_board[ym+r][xm+c] = 1'b1;
                    end
                end
            end
        end
        // Remove full rows; survivors keep their order and settle at the bottom.
        for (int y = H - 1; y >= 0; y--) begin
            if (m_board[y] == '1) n++;
            else                  kept.push_back(m_board[y]);
        end
        for (int y = H - 1; y >= 0; y--) begin
            if (H - 1 - y < kept.size()) m_board[y] = kept[H-1-y];
            else                         m_board[y] = '0;
        end
        m_lines     = 3'(n);
        m_total     = (m_total + n > 65535) ? 65535 : m_total + n;
        m_scan_left = H + n;
    endtask

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            model_reset_board();
            m_scan_left = 0; m_done = 1'b0; m_lines = '0; m_total = 0; m_ovf = 1'b0;
        end else if (clear_i) begin
            model_reset_board();
            m_scan_left = 0; m_done = 1'b0; m_lines = '0; m_ovf = 1'b0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_scan_left > 0) begin
            m_scan_left--;
            if (m_scan_left == 0) m_done = 1'b1;
        end else if (commit_v_i) begin
            model_commit(int'(commit_pos_i.x_m), int'(commit_pos_i.y_m), commit_shape_i);
        end
    end

    // ---------------------------------------------------------- compare
    always @(negedge clk_i) begin
        if (checking) begin
            check("ready_o",  32'(ready_o),    32'(m_scan_left == 0 && !m_done));
            check("done_o",   32'(done_o),     32'(m_done));
            check("overflow", 32'(overflow_o), 32'(m_ovf));
            if (m_scan_left == 0) begin
                check("lines_cleared", 32'(lines_cleared_o), 32'(m_lines));
                check("total_lines",   32'(total_lines_o),   32'(m_total));
                check("mm_data",       32'(mm_data_o),
                      32'(model_win(int'(mm_addr_i.x_m), int'(mm_addr_i.y_m))));
                check("row_data",      32'(row_data_o),      32'(model_row(int'(row_addr_i))));
            end
        end
    end

    // ---------------------------------------------------------- drivers
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic win_check(input string name, input int x, input int y, input logic [15:0] exp);
        mm_addr_i.x_m = 4'(x);
        mm_addr_i.y_m = 5'(y);
        #1;
        check(name, 32'(mm_data_o), 32'(exp));
    endtask

    task automatic row_check(input string name, input int a, input logic [W-1:0] exp);
        row_addr_i = 5'(a);
        #1;
        check(name, 32'(row_data_o), 32'(exp));
    endtask

    // Returns just after the accepting edge N.
    task automatic start_commit(input int x, input int y, input logic [15:0] sh);
        step();
        commit_pos_i.x_m = 4'(x);
        commit_pos_i.y_m = 5'(y);
        commit_shape_i   = sh;
        commit_v_i       = 1'b1;
        step();
        commit_v_i       = 1'b0;
    endtask

    // Reports the cycle number (relative to N) in which done_o is seen.
    // The cycle after edge N+j is cycle N+j+1. With inject_at >= 0, a stray
    // commit is driven during SCAN.
    task automatic wait_done(input int inject_at, output int cyc);
        cyc = -1;
        for (int j = 0; j < 60; j++) begin
            @(negedge clk_i);
            if (j == inject_at) begin
                commit_pos_i   = '0;
                commit_shape_i = 16'hFFFF;
                commit_v_i     = 1'b1;
            end else begin
                commit_v_i     = 1'b0;
            end
            if (done_o) begin
                cyc = j + 1;
                break;
            end
        end
        commit_v_i = 1'b0;
        if (cyc < 0) check("done_timeout", 32'd0, 32'd1);
        step();
    endtask

    task automatic run_commit(input int x, input int y, input logic [15:0] sh, output int cyc);
        start_commit(x, y, sh);
        wait_done(-1, cyc);
    endtask

    task automatic do_clear();
        step();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int pulses;

        reset_i        = 1'b1;
        mm_addr_i      = '0;
        commit_v_i     = 1'b0;
        commit_pos_i   = '0;
        commit_shape_i = '0;
        clear_i        = 1'b0;
        row_addr_i     = '0;
        repeat (2) @(posedge clk_i);
        #2;
        check("rst_ready",    32'(ready_o),         32'd1);
        check("rst_done",     32'(done_o),          32'd0);
        check("rst_lines",    32'(lines_cleared_o), 32'd0);
        check("rst_total",    32'(total_lines_o),   32'd0);
        check("rst_overflow", 32'(overflow_o),      32'd0);
        row_check("rst_row19", 19, '0);
        reset_i  = 1'b0;
        checking = 1'b1;

        // Window reads on an empty board.
        step();
        win_check("win_0_0",  0,  0, 16'h0000);
        win_check("win_8_0",  8,  0, 16'hCCCC);
        win_check("win_15_0", 15, 0, 16'hFFFF);
        win_check("win_0_18", 0, 18, 16'hFF00);

        // O-tile at (4,18).
        run_commit(4, 18, 16'h0033, cyc);
        check("o_done_cycle", 32'(cyc), 32'd21);
        row_check("o_row18", 18, 10'b0000110000);
        row_check("o_row19", 19, 10'b0000110000);
        check("o_lines", 32'(lines_cleared_o), 32'd0);
        step();
        win_check("o_win_4_17", 4, 17, 16'hF330);

        // Single line clear, with a block above that drops down.
        do_clear();
        run_commit(4, 19, 16'h000F, cyc);
        run_commit(8, 19, 16'h0003, cyc);
        run_commit(0, 18, 16'h0001, cyc);
        run_commit(0, 19, 16'h000F, cyc);
        check("i_done_cycle", 32'(cyc), 32'd22);
        check("i_lines", 32'(lines_cleared_o), 32'd1);
        check("i_total", 32'(total_lines_o),   32'd1);
        row_check("i_row19", 19, 10'b0000000001);
        step();
        row_check("i_row18", 18, '0);

        // Four-line clear.
        do_clear();
        run_commit(0, 16, 16'hFFFF, cyc);
        run_commit(4, 16, 16'hFFFF, cyc);
        run_commit(8, 16, 16'h1111, cyc);
        run_commit(9, 16, 16'h1111, cyc);
        check("tetris_done_cycle", 32'(cyc), 32'd25);
        check("tetris_lines", 32'(lines_cleared_o), 32'd4);
        check("tetris_total", 32'(total_lines_o),   32'd5);
        for (int y = 16; y < 20; y++) begin
            step();
            row_check("tetris_row", y, '0);
        end
        check("tetris_ovf", 32'(overflow_o), 32'd0);

        // Overflow: overlap, stickiness, clear, off-board bit.
        do_clear();
        run_commit(0, 19, 16'h0001, cyc);
        check("ovf_clean", 32'(overflow_o), 32'd0);
        run_commit(0, 19, 16'h0001, cyc);
        check("ovf_overlap", 32'(overflow_o), 32'd1);
        run_commit(3, 0, 16'h0001, cyc);
        check("ovf_sticky", 32'(overflow_o), 32'd1);
        do_clear();
        check("ovf_cleared", 32'(overflow_o),    32'd0);
        check("clear_total", 32'(total_lines_o), 32'd5);
        row_check("clear_row19", 19, '0);
        run_commit(0, 19, 16'h0010, cyc);
        check("ovf_offboard", 32'(overflow_o), 32'd1);
        row_check("offboard_dropped", 19, '0);
        do_clear();

        // A commit during SCAN is ignored.
        start_commit(0, 19, 16'h0001);
        wait_done(3, cyc);
        check("scan_commit_cycle", 32'(cyc), 32'd21);
        row_check("scan_commit_row0",  0,  '0);
        step();
        row_check("scan_commit_row19", 19, 10'b0000000001);

        // clear_i in the middle of SCAN.
        start_commit(4, 19, 16'h000F);
        repeat (5) @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check("midclear_ready", 32'(ready_o), 32'd1);
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_i);
            if (done_o) pulses++;
        end
        check("midclear_no_done", 32'(pulses), 32'd0);
        check("midclear_total", 32'(total_lines_o), 32'd5);

        // Asynchronous reset in the middle of SCAN.
        start_commit(0, 19, 16'h000F);
        repeat (5) @(negedge clk_i);
        #2;
        reset_i = 1'b1;
        #1;
        check("midrst_ready", 32'(ready_o),         32'd1);
        check("midrst_done",  32'(done_o),          32'd0);
        check("midrst_lines", 32'(lines_cleared_o), 32'd0);
        check("midrst_total", 32'(total_lines_o),   32'd0);
        check("midrst_ovf",   32'(overflow_o),      32'd0);
        row_check("midrst_row19", 19, '0);
        @(negedge clk_i);
        reset_i = 1'b0;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk_i);
            if (done_o) pulses++;
        end
        check("midrst_no_done", 32'(pulses), 32'd0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
